// File: rtl/uart_tx_unit.sv
// 8N1 UART transmitter: one byte per accepted request, LSB first, idle-high line.
// Outputs are registered so every line transition lands exactly on a clock edge.
//
// state     | meaning
// ----------+---------------------------------------------------------
// S_IDLE    | line high, waiting for i_TX_DV
// S_START   | driving start bit (0) for CLKS_PER_BIT cycles
// S_DATA    | driving data bit [bit_idx] for CLKS_PER_BIT cycles each
// S_STOP    | driving stop bit (1); final edge raises done, drops active
// S_CLEANUP | single cycle with done held high, then back to idle
module uart_tx_unit #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       i_Clock,
  input  logic       i_Rst_n,
  input  logic       i_TX_DV,
  input  logic [7:0] i_TX_Byte,
  output logic       o_TX_Active,
  output logic       o_uart_tx,
  output logic       o_TX_Done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_CLEANUP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    data_q, data_d;
  logic          tx_q, tx_d;
  logic          active_q, active_d;
  logic          done_q, done_d;
  logic          bit_end;

  // Bit timer is a down-counter; a bit period ends when it reaches zero.
  assign bit_end = (cnt_q == '0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    data_d   = data_q;
    tx_d     = tx_q;
    active_d = active_q;
    done_d   = done_q;

    case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        done_d = 1'b0;
        cnt_d  = '0;
        idx_d  = '0;
        if (i_TX_DV) begin
          data_d   = i_TX_Byte;
          active_d = 1'b1;
          tx_d     = 1'b0;
          cnt_d    = CNT_LOAD;
          state_d  = S_START;
        end
      end

      S_START: begin
        if (bit_end) begin
          idx_d   = '0;
          tx_d    = data_q[0];
          cnt_d   = CNT_LOAD;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      S_DATA: begin
        if (bit_end) begin
          cnt_d = CNT_LOAD;
          if (idx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = S_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
            tx_d  = data_q[idx_d];
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      S_STOP: begin
        if (bit_end) begin
          done_d   = 1'b1;
          active_d = 1'b0;
          cnt_d    = '0;
          state_d  = S_CLEANUP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      S_CLEANUP: begin
        done_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        tx_d     = 1'b1;
        active_d = 1'b0;
        done_d   = 1'b0;
        state_d  = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      data_q   <= '0;
      tx_q     <= 1'b1;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      tx_q     <= tx_d;
      active_q <= active_d;
      done_q   <= done_d;
    end
  end

  assign o_uart_tx   = tx_q;
  assign o_TX_Active = active_q;
  assign o_TX_Done   = done_q;

endmodule

// File: tb/tb_uart_tx_unit.sv
// Directed bench for uart_tx_unit with CLKS_PER_BIT=4; outputs sampled on the falling edge.
module tb_uart_tx_unit;

  localparam int C = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       dv = 1'b0;
  logic [7:0] byte_in = 8'h00;
  logic       tx_active;
  logic       uart_tx;
  logic       tx_done;

  int n_asserts = 0;
  int n_fails   = 0;

  uart_tx_unit #(.CLKS_PER_BIT(C)) dut (
    .i_Clock    (clk),
    .i_Rst_n    (rst_n),
    .i_TX_DV    (dv),
    .i_TX_Byte  (byte_in),
    .o_TX_Active(tx_active),
    .o_uart_tx  (uart_tx),
    .o_TX_Done  (tx_done)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk1({tag, " line"}, uart_tx, 1'b1);
    chk1({tag, " active"}, tx_active, 1'b0);
    chk1({tag, " done"}, tx_done, 1'b0);
  endtask

  // Caller raises dv at a falling edge; the next rising edge is the accepting edge.
  task automatic send_frame(input logic [7:0] b, input string tag, input bit hold_dv,
                            input int alt_k, input logic [7:0] alt_byte, input bit pulse_dv);
    logic [9:0] frame;
    logic [7:0] rx;
    frame = {1'b1, b, 1'b0};
    rx    = 8'h00;
    @(posedge clk);
    for (int k = 0; k < 10 * C; k++) begin
      @(negedge clk);
      chk1({tag, " line"}, uart_tx, frame[k / C]);
      chk1({tag, " active"}, tx_active, 1'b1);
      chk1({tag, " done"}, tx_done, 1'b0);
      if ((k % C) == 1 && (k / C) >= 1 && (k / C) <= 8) rx[(k / C) - 1] = uart_tx;
      if (k == 0 && !hold_dv) dv = 1'b0;
      if (k == alt_k) begin
        byte_in = alt_byte;
        if (pulse_dv) dv = 1'b1;
      end
      if (k == alt_k + 1 && pulse_dv) dv = 1'b0;
    end
    chk8({tag, " decoded"}, rx, b);
    @(negedge clk);
    chk1({tag, " done_pulse"}, tx_done, 1'b1);
    chk1({tag, " active_end"}, tx_active, 1'b0);
    chk1({tag, " line_end"}, uart_tx, 1'b1);
    @(negedge clk);
    chk1({tag, " done_clear"}, tx_done, 1'b0);
    chk1({tag, " active_idle"}, tx_active, 1'b0);
    chk1({tag, " line_gap"}, uart_tx, 1'b1);
  endtask

  initial begin
    // Asynchronous reset applied between edges must act immediately.
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk_idle("reset_async");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk_idle("post_reset");
    end

    dv = 1'b1; byte_in = 8'hA5;
    send_frame(8'hA5, "a5", 1'b0, -1, 8'h00, 1'b0);

    dv = 1'b1; byte_in = 8'h00;
    send_frame(8'h00, "b00", 1'b0, -1, 8'h00, 1'b0);

    dv = 1'b1; byte_in = 8'hFF;
    send_frame(8'hFF, "bff", 1'b0, -1, 8'h00, 1'b0);

    // Busy-time request and byte change must not disturb or follow the frame.
    dv = 1'b1; byte_in = 8'h3C;
    send_frame(8'h3C, "busy", 1'b0, 13, 8'hFF, 1'b1);
    repeat (12) begin
      @(negedge clk);
      chk_idle("busy_no_second");
    end

    // DV held: second start bit begins two cycles after the first stop bit ends.
    dv = 1'b1; byte_in = 8'h12;
    send_frame(8'h12, "b2b_0", 1'b1, 20, 8'h34, 1'b0);
    send_frame(8'h34, "b2b_1", 1'b0, -1, 8'h00, 1'b0);
    repeat (4) begin
      @(negedge clk);
      chk_idle("b2b_idle");
    end

    // Abort during data bit 3 (bit value 0 so the jump to high is visible).
    dv = 1'b1; byte_in = 8'hF0;
    @(posedge clk);
    @(negedge clk);
    dv = 1'b0;
    repeat (17) @(negedge clk);
    chk1("abort_bit3_line", uart_tx, 1'b0);
    chk1("abort_bit3_active", tx_active, 1'b1);
    #1 rst_n = 1'b0;
    #1 chk_idle("abort_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (50) begin
      @(negedge clk);
      chk_idle("abort_no_resume");
    end

    dv = 1'b1; byte_in = 8'h81;
    send_frame(8'h81, "b81", 1'b0, -1, 8'h00, 1'b0);
    repeat (3) begin
      @(negedge clk);
      chk_idle("final_idle");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
